// File: rtl/fifo_wr_arb.sv
// Round-robin write arbiter that shares one fifo_mf write port among NUM_REQ producers.
// A grant lasts up to MAX_BURST words, and then priority rotates to the next producer.
module fifo_wr_arb #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = 4,
    localparam int ID_WIDTH  = $clog2(NUM_REQ),
    localparam int BC_WIDTH  = $clog2(MAX_BURST + 1)
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          fifo_full,
    output logic                          fifo_wrreq,
    output logic [DATA_WIDTH-1:0]         fifo_data,
    output logic                          busy,
    output logic [ID_WIDTH-1:0]           owner,
    output logic [31:0]                   wr_count,
    output logic                          dbg_state,
    output logic [ID_WIDTH-1:0]           dbg_rr_ptr,
    output logic [BC_WIDTH-1:0]           dbg_burst_cnt
);

    // Handshake: word i transfers in a cycle where req_valid[i] & req_ready[i]; the producer
    // holds data and valid until then, and req_ready is combinational within the same cycle.

    typedef enum logic {IDLE, OWN} state_t;

    state_t                state, state_n;
    logic [ID_WIDTH-1:0]   rr_ptr, rr_ptr_n;
    logic [ID_WIDTH-1:0]   owner_n;
    logic [BC_WIDTH-1:0]   burst_cnt, burst_n;
    logic [31:0]           wr_cnt;

    logic [NUM_REQ-1:0]    grant;
    logic [ID_WIDTH-1:0]   sel;
    logic [ID_WIDTH-1:0]   win_id;
    logic [ID_WIDTH-1:0]   idx;
    logic                  win_found;

    function automatic logic [ID_WIDTH-1:0] next_id(input logic [ID_WIDTH-1:0] id);
        next_id = (id == ID_WIDTH'(NUM_REQ - 1)) ? '0 : id + 1'b1;
    endfunction

    // The search starts at rr_ptr and wraps at NUM_REQ.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        idx       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = ID_WIDTH'((int'(rr_ptr) + k) % NUM_REQ);
            if (!win_found && req_valid[idx]) begin
                win_found = 1'b1;
                win_id    = idx;
            end
        end
    end

    always_comb begin
        grant    = '0;
        sel      = owner;
        state_n  = state;
        rr_ptr_n = rr_ptr;
        owner_n  = owner;
        burst_n  = burst_cnt;
        case (state)
            IDLE: begin
                if (!fifo_full && win_found) begin
                    grant[win_id] = 1'b1;
                    sel           = win_id;
                    owner_n       = win_id;
                    if (MAX_BURST == 1) begin
                        rr_ptr_n = next_id(win_id);
                    end else begin
                        state_n = OWN;
                        burst_n = BC_WIDTH'(1);
                    end
                end
            end
            OWN: begin
                if (req_valid[owner]) begin
                    if (!fifo_full) begin
                        grant[owner] = 1'b1;
                        burst_n      = burst_cnt + 1'b1;
                        if (burst_n == BC_WIDTH'(MAX_BURST)) begin
                            state_n  = IDLE;
                            rr_ptr_n = next_id(owner);
                        end
                    end
                end else begin
                    // The owner went idle, so the grant is released and this cycle carries no write.
                    state_n  = IDLE;
                    rr_ptr_n = next_id(owner);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            owner     <= '0;
            burst_cnt <= '0;
            wr_cnt    <= '0;
        end else begin
            state     <= state_n;
            rr_ptr    <= rr_ptr_n;
            owner     <= owner_n;
            burst_cnt <= burst_n;
            if (fifo_wrreq) begin
                wr_cnt <= wr_cnt + 32'd1;
            end
        end
    end

    // Outputs are gated by reset_n so that asserting reset mid-burst stops the write at once.
    assign req_ready     = reset_n ? grant : '0;
    assign fifo_wrreq    = |req_ready;
    assign fifo_data     = fifo_wrreq ? req_data[int'(sel)*DATA_WIDTH +: DATA_WIDTH] : '0;
    assign busy          = (state == OWN);
    assign wr_count      = wr_cnt;
    assign dbg_state     = (state == OWN);
    assign dbg_rr_ptr    = rr_ptr;
    assign dbg_burst_cnt = burst_cnt;

endmodule
